// File: rtl/pri_enc_pkg.sv
// Shared definitions for the pri_enc_arb request arbiter.
//   MODE_FIXED / MODE_RR : selection policy codes for the MODE parameter
//   N_MAX                : widest supported request vector
//   onehot(idx, n)       : one-hot mask with bit idx set (zero when idx is out of range)
package pri_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  localparam int N_MAX      = 64;

  function automatic logic [N_MAX-1:0] onehot(input int idx, input int n);
    return (idx >= 0 && idx < n) ? (N_MAX'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/pri_enc_core.sv
// Combinational find-highest-set encoder.
//   vec   : input vector to search
//   idx   : index of the highest set bit of vec (0 when vec is empty)
//   found : vec has at least one bit set
module pri_enc_core #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise a latch is inferred.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Ascending scan: the last hit is the highest set index.
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pri_enc_arb.sv
// Registered priority-encoding arbiter. Requests accumulate in a sticky pending
// register; each pending request is served once as an encoded index over a
// valid/ready handshake. MODE selects fixed priority (highest index wins) or
// round-robin (search descends from last_grant-1, wrapping).
//   clk        : clock, all state on the rising edge
//   rst_n      : synchronous active-low reset
//   en         : sample req into pending when 1
//   req        : request lines, level-sampled each enabled edge
//   clear_all  : flush pending, output register and ovf (round-robin pointer kept)
//   out_valid  : out_idx holds a granted index
//   out_ready  : consumer accepts out_idx when out_valid && out_ready
//   out_idx    : encoded index of the granted request
//   any_pend   : at least one request pending (excludes the output register)
//   ovf        : sticky, a request arrived while the same bit was still pending
module pri_enc_arb
  import pri_enc_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = MODE_FIXED,
  localparam int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         clear_all,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         any_pend,
  output logic         ovf
);

  localparam logic [W:0] N_EXT = (W+1)'(N);

  logic [N-1:0] pending;
  logic [N-1:0] clr_mask;
  logic [N-1:0] search_vec;
  logic [W-1:0] last_grant;
  logic [W-1:0] core_idx;
  logic [W-1:0] sel;
  logic [W:0]   unrot_sum;
  logic         core_found;
  logic         may_load;
  logic         load;

  // Round-robin: rotate pending right by last_grant so bit (last_grant-1) mod N
  // lands at position N-1, where the highest-set search begins.
  always_comb begin
    search_vec = pending;
    if (MODE == MODE_RR) begin
      search_vec = N'({pending, pending} >> last_grant);
    end
  end

  pri_enc_core #(.N(N)) u_core (
    .vec   (search_vec),
    .idx   (core_idx),
    .found (core_found)
  );

  // Undo the rotation: sel = (core_idx + last_grant) mod N.
  always_comb begin
    unrot_sum = {1'b0, core_idx} + {1'b0, last_grant};
    sel       = core_idx;
    if (MODE == MODE_RR) begin
      sel = (unrot_sum >= N_EXT) ? W'(unrot_sum - N_EXT) : W'(unrot_sum);
    end
  end

  assign may_load = !out_valid || out_ready;
  assign load     = may_load && core_found;
  assign clr_mask = load ? N'(onehot(int'(sel), N)) : '0;
  assign any_pend = |pending;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending    <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      ovf        <= 1'b0;
      last_grant <= '0;
    end else if (clear_all) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      ovf       <= 1'b0;
    end else begin
      // A bit being granted this edge may re-pend without counting as overflow.
      pending <= (pending & ~clr_mask) | (en ? req : '0);
      if (en && |(req & pending & ~clr_mask)) begin
        ovf <= 1'b1;
      end
      if (load) begin
        out_valid  <= 1'b1;
        out_idx    <= sel;
        last_grant <= sel;
      end else if (may_load) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
